// File: rtl/music_pkg.sv
// Shared note-format constants, state/duration enums and the half-period lookup
// used by the melody player and its ROM.
package music_pkg;

  localparam int NOTE_W = 8;
  localparam int DUR_W  = 2;
  localparam int OCT_W  = 2;
  localparam int DEG_W  = 4;

  localparam logic [DEG_W-1:0] DEG_REST = 4'd0;
  localparam logic [DEG_W-1:0] DEG_END  = 4'd15;

  localparam logic [31:0] MID_HP [7] = '{
    32'd95602, 32'd85179, 32'd75873, 32'd71633, 32'd63776, 32'd56818, 32'd50607
  };

  typedef enum logic [1:0] {DUR_16, DUR_8, DUR_4, DUR_2} dur_e;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_GAP, ST_TONE} state_e;

  // Reserved octave 3 falls through to mid; a result that scales to 0 is held at 1.
  function automatic logic [31:0] half_period(input logic [OCT_W-1:0] oct,
                                              input logic [DEG_W-1:0] deg,
                                              input int shift);
    logic [2:0]  sel;
    logic [31:0] hp;
    sel = (deg[2:0] == 3'd0) ? 3'd0 : deg[2:0] - 3'd1;
    hp  = MID_HP[sel];
    case (oct)
      2'd0:    hp = hp << 1;
      2'd2:    hp = hp >> 1;
      default: hp = hp;
    endcase
    hp = hp >> shift;
    if (hp == 32'd0) hp = 32'd1;
    return hp;
  endfunction

endpackage

// File: rtl/melody_player_if.sv
// Control/status bundle between the keypad/mode logic (master) and the player (slave).
interface melody_player_if #(
  parameter int SONG_CNT = 3,
  parameter int MAX_LEN  = 64
);
  localparam int SEL_W = (SONG_CNT > 1) ? $clog2(SONG_CNT) : 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [SEL_W-1:0] song_sel;
  logic             start;
  logic             stop;
  logic             pause;
  logic             loop;
  logic             pwm;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] note_idx;

  modport master (output song_sel, start, stop, pause, loop,
                  input  pwm, busy, done, note_idx);
  modport slave  (input  song_sel, start, stop, pause, loop,
                  output pwm, busy, done, note_idx);
endinterface

// File: rtl/melody_player_rom.sv
// Synchronous-read song ROM addressed by {song, index}; unlisted entries read as rest.
// Song 0 is Twinkle Twinkle Little Star, song 1 a single note, song 2 has no END marker.
module melody_rom #(
  parameter int SONG_CNT = 3,
  parameter int MAX_LEN  = 64,
  localparam int SEL_W = (SONG_CNT > 1) ? $clog2(SONG_CNT) : 1,
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] song,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       entry
);

  logic [7:0] entry_d, entry_q;

  always_comb begin
    entry_d = 8'h00;
    case (32'(song))
      32'd0: begin
        case (32'(idx))
          32'd0, 32'd1, 32'd13: entry_d = (32'(idx) == 32'd13) ? 8'hD1 : 8'h91;
          32'd2, 32'd3:         entry_d = 8'h95;
          32'd4, 32'd5:         entry_d = 8'h96;
          32'd6:                entry_d = 8'hD5;
          32'd7, 32'd8:         entry_d = 8'h94;
          32'd9, 32'd10:        entry_d = 8'h93;
          32'd11, 32'd12:       entry_d = 8'h92;
          32'd14:               entry_d = 8'h0F;
          default:              entry_d = 8'h00;
        endcase
      end
      32'd1: begin
        case (32'(idx))
          32'd0:   entry_d = 8'h11;
          32'd1:   entry_d = 8'h0F;
          default: entry_d = 8'h00;
        endcase
      end
      32'd2: entry_d = (32'(idx) == 32'd0) ? 8'h41 : 8'h00;
      default: entry_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry_q <= 8'h00;
    else        entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/melody_player.sv
// Multi-song melody sequencer: fetches note entries, times gap/tone per note and
// divides the clock into a square wave on pwm.
//   state    | meaning
//   ST_IDLE  | stopped, pwm low
//   ST_FETCH | ROM entry for {song, note_idx} valid; decode or END handling
//   ST_GAP   | leading silence of the current note
//   ST_TONE  | sounding part, pwm toggles every half-period
module melody_player
  import music_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SONG_CNT = 3,
  parameter int MAX_LEN  = 64,
  parameter int TONE_CYC = 10_000_000,
  parameter int GAP_CYC  = 2_500_000,
  parameter int HP_SHIFT = 0
) (
  input logic            clk,
  input logic            rst_n,
  melody_player_if.slave bus
);

  localparam int SEL_W = (SONG_CNT > 1) ? $clog2(SONG_CNT) : 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [31:0]      GAP32      = 32'(GAP_CYC);
  localparam logic [31:0]      TONE32     = 32'(TONE_CYC);
  localparam logic [31:0]      SONG_CNT32 = 32'(SONG_CNT);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(MAX_LEN - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] song_q, song_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      hp_cnt_q, hp_cnt_d;
  logic [31:0]      hp_q, hp_d;
  dur_e             dur_q, dur_d;
  logic             rest_q, rest_d;
  logic             pwm_q, pwm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       entry;
  logic             start_ok, frozen, entry_end;
  logic             unused_clk_hz;

  assign unused_clk_hz = ^(32'(CLK_HZ));

  // ROM is addressed with next-cycle values so the entry is ready in FETCH.
  melody_rom #(.SONG_CNT(SONG_CNT), .MAX_LEN(MAX_LEN)) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .song  (song_d),
    .idx   (idx_d),
    .entry (entry)
  );

  assign start_ok  = bus.start && !bus.stop && (32'(bus.song_sel) < SONG_CNT32);
  assign frozen    = bus.pause && ((state_q == ST_GAP) || (state_q == ST_TONE));
  assign entry_end = (entry[3:0] == DEG_END) || last_q;

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    idx_d    = idx_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    hp_cnt_d = hp_cnt_q;
    hp_d     = hp_q;
    dur_d    = dur_q;
    rest_d   = rest_q;
    pwm_d    = 1'b0;
    done_d   = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
    end else if (start_ok) begin
      state_d = ST_FETCH;
      song_d  = bus.song_sel;
      idx_d   = '0;
      last_d  = 1'b0;
    end else if (!frozen) begin
      case (state_q)
        ST_FETCH: begin
          if (entry_end) begin
            if (bus.loop) begin
              idx_d  = '0;
              last_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_GAP;
            dur_d   = dur_e'(entry[7:6]);
            rest_d  = (entry[3:0] == DEG_REST) || (entry[3:0] > 4'd7);
            hp_d    = half_period(entry[5:4], entry[3:0], HP_SHIFT);
            cnt_d   = (GAP32 << entry[7:6]) - 32'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == 32'd0) begin
            state_d  = ST_TONE;
            cnt_d    = (TONE32 << dur_q) - 32'd1;
            hp_cnt_d = 32'd0;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_TONE: begin
          if (cnt_q == 32'd0) begin
            state_d = ST_FETCH;
            // Past the last slot the next fetch is forced to behave as END.
            if (idx_q == IDX_LAST) last_d = 1'b1;
            else                   idx_d  = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q - 32'd1;
            if (hp_cnt_q == hp_q - 32'd1) begin
              hp_cnt_d = 32'd0;
              pwm_d    = ~pwm_q & ~rest_q;
            end else begin
              hp_cnt_d = hp_cnt_q + 32'd1;
              pwm_d    = pwm_q & ~rest_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      song_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      cnt_q    <= 32'd0;
      hp_cnt_q <= 32'd0;
      hp_q     <= 32'd0;
      dur_q    <= DUR_16;
      rest_q   <= 1'b0;
      pwm_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      hp_cnt_q <= hp_cnt_d;
      hp_q     <= hp_d;
      dur_q    <= dur_d;
      rest_q   <= rest_d;
      pwm_q    <= pwm_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.pwm      = pwm_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.note_idx = idx_q;

endmodule
